// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle control FSM for the RV32 core
// Sequences fetch/decode/exec/mem/wb over the shared memory, register file and ALU.
module multicycle_ctrl #(
   parameter int WIDTH       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic       rf_we,
   output logic       alu_src_b,
   output logic       imm_sel,
   output logic [3:0] alu_op,
   output logic       wb_sel,
   output logic       retire,
   output logic       trap,
   output logic [1:0] trap_cause
);

   localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      C_R,
      C_I,
      C_LOAD,
      C_STORE
   } cls_t;

   state_t        state;
   cls_t          cls_q;
   logic [3:0]    alu_op_q;
   logic [CW-1:0] wait_cnt;
   logic          trap_q;
   logic [1:0]    cause_q;

   logic          mem_phase;
   logic          timeout_hit;

   // Only funct7[5] selects the alternate ALU operation.
   logic          unused_bits;
   logic [31:0]   unused_width;
   assign unused_bits  = ^{funct7[6], funct7[4:0]};
   assign unused_width = WIDTH;

   assign mem_phase   = (state == S_FETCH) || (state == S_MEM);
   assign timeout_hit = (MEM_TIMEOUT != 0) && mem_phase && !mem_ready &&
                        (wait_cnt == CW'(MEM_TIMEOUT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         cls_q    <= C_R;
         alu_op_q <= 4'b0000;
         wait_cnt <= '0;
         trap_q   <= 1'b0;
         cause_q  <= 2'b00;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) begin
                  state <= S_DECODE;
               end else if (timeout_hit) begin
                  state   <= S_TRAP;
                  trap_q  <= 1'b1;
                  cause_q <= 2'b10;
               end
            end
            S_DECODE: begin
               case (opcode)
                  OP_R: begin
                     cls_q    <= C_R;
                     alu_op_q <= {funct7[5], funct3};
                     state    <= S_EXEC;
                  end
                  OP_I: begin
                     cls_q    <= C_I;
                     alu_op_q <= {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                     state    <= S_EXEC;
                  end
                  OP_LOAD: begin
                     cls_q    <= C_LOAD;
                     alu_op_q <= 4'b0000;
                     state    <= S_EXEC;
                  end
                  OP_STORE: begin
                     cls_q    <= C_STORE;
                     alu_op_q <= 4'b0000;
                     state    <= S_EXEC;
                  end
                  default: begin
                     state   <= S_TRAP;
                     trap_q  <= 1'b1;
                     cause_q <= 2'b01;
                  end
               endcase
            end
            S_EXEC: begin
               state <= ((cls_q == C_LOAD) || (cls_q == C_STORE)) ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (mem_ready) begin
                  state <= (cls_q == C_LOAD) ? S_WB : S_FETCH;
               end else if (timeout_hit) begin
                  state   <= S_TRAP;
                  trap_q  <= 1'b1;
                  cause_q <= 2'b10;
               end
            end
            S_WB:    state <= S_FETCH;
            S_TRAP:  state <= S_TRAP;
            default: state <= S_FETCH;
         endcase

         // Counts consecutive unanswered requests; any transfer or state change clears it.
         if (mem_phase && !mem_ready && !timeout_hit) begin
            if (wait_cnt != {CW{1'b1}}) begin
               wait_cnt <= wait_cnt + CW'(1);
            end
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      rf_we     = 1'b0;
      alu_src_b = 1'b0;
      imm_sel   = 1'b0;
      alu_op    = 4'b0000;
      wb_sel    = 1'b0;
      retire    = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_req = 1'b1;
               ir_we   = mem_ready;
               pc_we   = mem_ready;
            end
            S_EXEC: begin
               alu_src_b = (cls_q != C_R);
               imm_sel   = (cls_q == C_STORE);
               alu_op    = alu_op_q;
            end
            S_MEM: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
               mem_we   = (cls_q == C_STORE);
               alu_op   = alu_op_q;
               retire   = (cls_q == C_STORE) && mem_ready;
            end
            S_WB: begin
               rf_we  = 1'b1;
               retire = 1'b1;
               wb_sel = (cls_q == C_LOAD);
               alu_op = alu_op_q;
            end
            default: ;
         endcase
      end
   end

   assign trap       = trap_q & ~rst;
   assign trap_cause = rst ? 2'b00 : cause_q;

endmodule
